// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, message-locked arbiter feeding one UART TX byte port
// A grant is held from first byte to req_last; a watchdog frees a grant whose owner goes quiet.
module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [8*N-1:0]       req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [N-1:0]         grant,
  output logic                 busy,
  output logic                 timeout_pulse,
  output logic [$clog2(N)-1:0] timeout_id
);

  localparam int IW = $clog2(N);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  logic [0:0]    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          tpulse_q, tpulse_d;
  logic [IW-1:0] tid_q, tid_d;

  logic          xfer;
  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] idx;

  assign busy          = (state_q == S_LOCKED);
  assign grant         = grant_q;
  assign tx_valid      = busy & req_valid[owner_q];
  assign req_ready     = grant_q & {N{tx_ready}};
  assign xfer          = tx_valid & tx_ready;
  assign timeout_pulse = tpulse_q;
  assign timeout_id    = tid_q;

  always_comb begin
    tx_data = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_q == IW'(i)) tx_data = req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    wd_d     = wd_q;
    tpulse_d = 1'b0;
    tid_d    = tid_q;
    found    = 1'b0;
    pick     = '0;
    idx      = '0;

    // Search starts just after the last owner so every requester gets its turn.
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(ptr_q) + i) % N);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_LOCKED;
          grant_d = N'(1) << pick;
          owner_d = pick;
          wd_d    = '0;
        end
      end
      default: begin
        if (xfer) begin
          wd_d = '0;
          if (req_last[owner_q]) begin
            state_d = S_IDLE;
            grant_d = '0;
            ptr_d   = owner_q;
          end
        end else if (!req_valid[owner_q]) begin
          // Only an absent owner counts; TX backpressure leaves the watchdog alone.
          if (wd_q >= WD_LAST) begin
            state_d  = S_IDLE;
            grant_d  = '0;
            ptr_d    = owner_q;
            wd_d     = '0;
            tpulse_d = 1'b1;
            tid_d    = owner_q;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      ptr_q    <= IW'(N - 1);
      wd_q     <= '0;
      tpulse_q <= 1'b0;
      tid_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      wd_q     <= wd_d;
      tpulse_q <= tpulse_d;
      tid_q    <= tid_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench with a message-level reference model
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic           tx_valid, tx_ready, busy, timeout_pulse;
  logic [7:0]     tx_data;
  logic [1:0]     timeout_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse), .timeout_id(timeout_id)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Requester byte queues; hold[i] forces a requester silent while it still has bytes.
  logic [7:0] qd[N][$];
  bit         ql[N][$];
  bit         hold[N];
  bit         hs[N];

  task automatic push(input int i, input logic [7:0] d, input bit l);
    qd[i].push_back(d);
    ql[i].push_back(l);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (qd[i].size() > 0 && !hold[i]) begin
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = qd[i][0];
        req_last[i]         = ql[i][0];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[8*i +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) hs[i] = req_valid[i] & req_ready[i];
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        void'(qd[i].pop_front());
        void'(ql[i].pop_front());
      end
    end
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      qd[i].delete();
      ql[i].delete();
      hold[i] = 1'b0;
    end
    tx_ready = 1'b1;
    drive();
    run(2);
    rst = 1'b0;
  endtask

  // Reference model: owner as an integer (-1 = nobody), rotating start point, quiet-cycle count.
  int m_owner, m_ptr, m_cnt, m_tid;
  bit m_pulse;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= -1;
      m_ptr   <= N - 1;
      m_cnt   <= 0;
      m_pulse <= 1'b0;
      m_tid   <= 0;
    end else begin : upd
      int o, p, c, t;
      bit pl;
      o = m_owner; p = m_ptr; c = m_cnt; t = m_tid; pl = 1'b0;
      if (o < 0) begin
        for (int k = 1; k <= N; k++) begin
          if (o < 0 && req_valid[(p + k) % N]) begin
            o = (p + k) % N;
            c = 0;
          end
        end
      end else if (req_valid[o] && tx_ready) begin
        c = 0;
        if (req_last[o]) begin
          p = o;
          o = -1;
        end
      end else if (!req_valid[o]) begin
        c++;
        if (c == TO) begin
          p = o; t = o; pl = 1'b1; o = -1; c = 0;
        end
      end
      m_owner <= o;
      m_ptr   <= p;
      m_cnt   <= c;
      m_pulse <= pl;
      m_tid   <= t;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] lg_d[$];
  int         lg_s[$];
  int         lg_c[$];
  int         pulse_n = 0;
  int         pulse_cyc = 0;
  int         bad_rdy = 0;
  int         bad_foreign = 0;

  always @(negedge clk) begin
    if (!rst) begin : cmp
      logic [N-1:0] eg;
      bit ev;
      int src;
      eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
      ev = (m_owner >= 0) && req_valid[m_owner];
      chk("grant", grant, eg);
      chk("busy", busy, m_owner >= 0);
      chk("tx_valid", tx_valid, ev);
      if (ev) chk("tx_data", tx_data, req_data[8*m_owner +: 8]);
      chk("req_ready", req_ready, tx_ready ? eg : '0);
      chk("timeout_pulse", timeout_pulse, m_pulse);
      chk("timeout_id", timeout_id, m_tid);

      src = -1;
      for (int k = 0; k < N; k++) if (grant[k]) src = k;
      if (tx_valid && tx_ready) begin
        lg_d.push_back(tx_data);
        lg_s.push_back(src);
        lg_c.push_back(cyc);
      end
      if (timeout_pulse) begin
        pulse_n   <= pulse_n + 1;
        pulse_cyc <= cyc;
      end
      if (!tx_ready && req_ready != '0) bad_rdy <= bad_rdy + 1;
      for (int k = 0; k < N; k++) begin
        if (req_valid[k] && req_ready[k] && !grant[k]) bad_foreign <= bad_foreign + 1;
      end
    end
  end

  task automatic chk_log(input string name, input int pos, input logic [7:0] d, input int s, input int c);
    chk({name, "_data"}, lg_d[pos], d);
    chk({name, "_src"},  lg_s[pos], s);
    chk({name, "_cyc"},  lg_c[pos], c);
  endtask

  int a, b, d0, p0, r0, f0;
  logic [7:0] ed;

  initial begin
    req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b1;
    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_timeout_pulse", timeout_pulse, 0);
    chk("rst_timeout_id", timeout_id, 0);

    // Single 3-byte message from requester 0.
    b = lg_d.size(); a = cyc;
    push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 1); drive();
    run(1);
    chk("t1_grant", grant, 4'b0001);
    run(3);
    chk("t1_idle_grant", grant, 0);
    chk("t1_idle_busy", busy, 0);
    run(1);
    chk("t1_count", lg_d.size() - b, 3);
    for (int k = 0; k < 3; k++) begin
      ed = 8'h41 + 8'(k);
      chk_log("t1", b + k, ed, 0, a + 1 + k);
    end

    // All four requesters: order 0,1,2,3,0 with one bubble between messages.
    do_reset();
    b = lg_d.size(); a = cyc;
    for (int i = 0; i < N; i++) begin
      push(i, 8'(16 * i + 1), 0);
      push(i, 8'(16 * i + 2), 1);
    end
    push(0, 8'h05, 0); push(0, 8'h06, 1); drive();
    run(20);
    chk("t2_count", lg_d.size() - b, 10);
    for (int m = 0; m < 5; m++) begin
      ed = (m < 4) ? 8'(16 * m + 1) : 8'h05;
      chk_log("t2_first", b + 2 * m, ed, m % N, a + 1 + 3 * m);
      ed = ed + 8'd1;
      chk_log("t2_last", b + 2 * m + 1, ed, m % N, a + 2 + 3 * m);
    end

    // Long TX backpressure on owner 2 is not a timeout.
    do_reset();
    b = lg_d.size(); a = cyc; p0 = pulse_n; r0 = bad_rdy;
    push(2, 8'h21, 0); push(2, 8'h22, 0); push(2, 8'h23, 1); drive();
    run(2);
    tx_ready = 1'b0;
    run(10000);
    chk("t3_no_pulse", pulse_n - p0, 0);
    chk("t3_no_ready", bad_rdy - r0, 0);
    chk("t3_still_owner", grant, 4'b0100);
    tx_ready = 1'b1;
    run(4);
    chk("t3_count", lg_d.size() - b, 3);
    chk_log("t3_b0", b, 8'h21, 2, a + 1);
    chk_log("t3_b1", b + 1, 8'h22, 2, a + 10002);
    chk_log("t3_b2", b + 2, 8'h23, 2, a + 10003);

    // Owner 1 goes silent mid-message; watchdog hands over to requester 2.
    do_reset();
    b = lg_d.size(); a = cyc; p0 = pulse_n;
    push(1, 8'h31, 0); push(1, 8'h32, 1); push(2, 8'h51, 1); drive();
    run(2);
    hold[1] = 1'b1; drive(); d0 = cyc;
    run(20);
    chk("t4_pulse_count", pulse_n - p0, 1);
    chk("t4_pulse_cyc", pulse_cyc, d0 + TO);
    chk("t4_timeout_id", timeout_id, 1);
    chk("t4_count", lg_d.size() - b, 2);
    chk_log("t4_b0", b, 8'h31, 1, a + 1);
    chk_log("t4_next", b + 1, 8'h51, 2, d0 + TO + 1);
    qd[1].delete(); ql[1].delete(); hold[1] = 1'b0; drive();

    // Requester 3 waits out a 5-byte message from owner 0.
    do_reset();
    b = lg_d.size(); a = cyc; f0 = bad_foreign;
    for (int k = 0; k < 5; k++) push(0, 8'hA1 + 8'(k), k == 4);
    push(3, 8'h71, 0); push(3, 8'h72, 1); drive();
    run(12);
    chk("t5_no_foreign_ready", bad_foreign - f0, 0);
    chk("t5_count", lg_d.size() - b, 7);
    for (int k = 0; k < 5; k++) begin
      ed = 8'hA1 + 8'(k);
      chk_log("t5_own", b + k, ed, 0, a + 1 + k);
    end
    chk_log("t5_r3a", b + 5, 8'h71, 3, a + 7);
    chk_log("t5_r3b", b + 6, 8'h72, 3, a + 8);

    // Asynchronous reset mid-message clears outputs without a clock edge.
    do_reset();
    b = lg_d.size();
    push(1, 8'h61, 0); push(1, 8'h62, 1); drive();
    run(2);
    push(0, 8'h01, 1); drive();
    chk("t6_pre_tx_valid", tx_valid, 1);
    chk("t6_pre_grant", grant, 4'b0010);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_tx_valid", tx_valid, 0);
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_req_ready", req_ready, 0);
    chk("t6_rst_busy", busy, 0);
    run(2);
    rst = 1'b0; a = cyc;
    run(5);
    chk("t6_count", lg_d.size() - b, 3);
    chk_log("t6_pre", b, 8'h61, 1, lg_c[b]);
    chk_log("t6_first", b + 1, 8'h01, 0, a + 1);
    chk_log("t6_second", b + 2, 8'h62, 1, a + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter byte interface among N byte-stream requesters (LED/status reporters, loopback echo, debug dump). A grant is held for a whole message, delimited by a per-requester last flag, so bytes from different sources never interleave on serial_tx. A watchdog releases a grant whose owner stalls mid-message. Sits between the requesters and the UART TX shifter/baud divider.

Parameters:
N, 4, number of requesters (2..8)
TIMEOUT, 4096, clk cycles a granted requester may hold req_valid low mid-message before forced release (>=2)

Ports:
clk  in  1  system clock (40 MHz)
rst  in  1  asynchronous, active-high reset
req_valid  in  N  requester i has a byte
req_data  in  8*N  byte of requester i at bits [8i+7:8i]
req_last  in  N  byte of requester i is the final byte of its message
req_ready  out  N  byte of requester i accepted this cycle when req_valid[i]&req_ready[i]
tx_valid  out  1  byte offered to UART TX
tx_data  out  8  byte to UART TX
tx_ready  in  1  UART TX accepts byte (transfer = tx_valid & tx_ready)
grant  out  N  one-hot current owner, all-zero when idle
busy  out  1  a grant is held
timeout_pulse  out  1  one-cycle pulse on forced release
timeout_id  out  clog2(N)  index of requester last released by timeout

Behaviour:
- Reset (async, immediate): state IDLE, grant=0, busy=0, timeout_pulse=0, timeout_id=0, watchdog=0, rr pointer=N-1 (requester 0 wins first). Outputs derived from grant drop in the same instant: tx_valid=0, req_ready=0.
- States: IDLE, LOCKED.
- IDLE: if any req_valid, choose the first set bit searching from pointer+1 upward, wrapping modulo N; register grant=onehot(choice), busy=1, go LOCKED next edge. No transfer occurs in IDLE; arbitration latency = 1 cycle from req_valid to grant.
- LOCKED (owner g): combinational path tx_valid=req_valid[g], tx_data=req_data[g], req_ready[g]=tx_ready, req_ready[others]=0. Non-owners' req_valid ignored.
- Transfer with req_last[g]=1: next edge -> IDLE, grant=0, busy=0, pointer=g. Minimum 1 idle cycle between messages (one-cycle bubble, required).
- Transfer with req_last[g]=0: stay LOCKED.
- Watchdog: width clog2(TIMEOUT+1); cleared on entry to LOCKED and on every transfer; increments each LOCKED cycle req_valid[g]=0; saturates. Does not count while req_valid[g]=1 and tx_ready=0 (TX backpressure is never a timeout).
- Watchdog reaching TIMEOUT: next edge -> IDLE, grant=0, pointer=g, timeout_pulse=1 for exactly one cycle, timeout_id=g (holds until next timeout or reset).
- Simultaneous last-transfer and watchdog expiry: impossible by construction (transfer clears counter); transfer has priority if coded otherwise; no timeout_pulse.
- Single requester continuously valid: re-granted after each bubble; no starvation: any requester valid continuously is granted within N-1 messages.
- Requester deasserts req_valid in IDLE before grant registers: grant still issued; watchdog later releases if it never returns.
- tx_data is don't-care when tx_valid=0; bench must not check it.

Test Plan:
- Reset then req_valid=4'b0001, 3-byte message 0x41,0x42,0x43 (last on third), tx_ready=1 -> grant=0001 one cycle later, tx_data 0x41,0x42,0x43 on consecutive cycles, grant=0 and busy=0 the cycle after 0x43.
- All four requesters valid with 2-byte messages -> grant order 0,1,2,3,0; exactly one idle cycle between messages; no bytes interleaved.
- Owner 2 mid-message, tx_ready held 0 for 10000 cycles -> no timeout_pulse, req_ready[2]=0 throughout, transfer resumes when tx_ready=1.
- Owner 1 sends one non-last byte then drops req_valid; TIMEOUT=16 -> timeout_pulse single cycle 16 cycles after the drop, timeout_id=1, grant moves to requester 2 if valid.
- Requester 3 valid while owner 0 streams a 5-byte message -> req_ready[3]=0 throughout; grant=1000 after the bubble (pointer=0, requesters 1,2 idle).
- Assert rst mid-message (owner 1, second byte pending) -> tx_valid, grant, req_ready all 0 without a clock edge; after release, requester 0 wins first.
